cmp_result_monitor: RTL and testbench
=====================================

Name: cmp_result_monitor

Overview:
Sequential stage directly downstream of Equalitycomparator_4bit. It samples the comparator's a_gt_b / a_lt_b / a_eq_b flags on a valid strobe and keeps saturating per-class event counts. It also detects a run of consecutive equal results (lock) and flags illegal, non-one-hot flag encodings. Its outputs feed status/debug logic and the LED/readout path.

Parameters:
CNT_W, 8, width of each event counter; counters saturate at 2^CNT_W-1.
LOCK_N, 4, consecutive valid a_eq_b samples required to assert eq_lock; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  comparator flags are sampled this cycle
a_gt_b  input  1  comparator flag, a > b
a_lt_b  input  1  comparator flag, a < b
a_eq_b  input  1  comparator flag, a == b
clr  input  1  synchronous clear of counters, lock and err; does not touch out_valid timing
gt_cnt  output  CNT_W  count of accepted gt samples
lt_cnt  output  CNT_W  count of accepted lt samples
eq_cnt  output  CNT_W  count of accepted eq samples
last_res  output  2  last accepted result: 00 none, 01 gt, 10 lt, 11 eq
out_valid  output  1  one-cycle pulse, registered outputs updated from an accepted sample
eq_lock  output  1  high while in LOCK state
err  output  1  sticky, illegal flag encoding seen

Behaviour:
- Clocking: single clock domain, synchronous active-high reset; no async paths.
- Reset (rst=1): all counters 0, last_res=00, out_valid=0, eq_lock=0, err=0, streak=0, state=IDLE. rst overrides clr and in_valid.
- Legal sample: in_valid=1 and exactly one flag high.
- Illegal sample: in_valid=1 and flag count 0, 2 or 3.
- Flags are ignored when in_valid=0.
- Latency: 1 cycle. A sample at edge N is reflected in counters, last_res and eq_lock after edge N+1, with out_valid=1 for that one cycle. out_valid=0 on cycles with no accepted sample.
- Counters: the matching counter increments by 1 per legal sample and holds at all-ones (no wrap). The other counters hold.
- Streak counter:
  - internal, width sized to hold LOCK_N.
  - increments on legal eq, saturating at LOCK_N.
  - clears to 0 on legal gt/lt.
  - holds on idle cycles; gaps in in_valid do not break a streak.
- States:
  - IDLE: no sample since reset/clr.
    - legal eq -> TRACK, or LOCK if LOCK_N=1.
    - legal gt/lt -> TRACK.
    - illegal -> ERR.
  - TRACK:
    - legal eq with streak reaching LOCK_N -> LOCK.
    - illegal -> ERR.
    - otherwise stay.
  - LOCK: eq_lock=1.
    - legal gt/lt -> TRACK, with eq_lock=0 next cycle.
    - illegal -> ERR.
    - eq -> stay.
  - ERR: err=1, eq_lock=0.
    - Further samples are ignored: counters, last_res and streak frozen, out_valid stays 0.
    - Exit only via clr or rst -> IDLE.
- Illegal sample handling: the sample that causes ERR produces no counter update and no out_valid. err rises the cycle after it.
- clr=1: next cycle counters=0, last_res=00, streak=0, eq_lock=0, err=0, state=IDLE, out_valid=0.
  - clr together with in_valid: clr wins and the sample is dropped.
- Back-to-back in_valid every cycle is supported at full rate; no backpressure.

Test Plan:
- rst held 2 cycles, then released -> all outputs 0, last_res=00.
- Valid samples for (a,b) = (14,10), (14,15), (14,14), (12,10), i.e. gt, lt, eq, gt -> gt_cnt=2, lt_cnt=1, eq_cnt=1, last_res=01, four out_valid pulses each 1 cycle after its sample, eq_lock=0.
- LOCK_N=4: four eq samples (14,14) with one idle cycle between the 2nd and 3rd, then one gt sample -> eq_lock rises 1 cycle after the 4th eq and falls 1 cycle after the gt; eq_cnt=4.
- Illegal sample a_gt_b=a_eq_b=1 with in_valid=1 -> err=1 next cycle, no out_valid, counters unchanged. Subsequent legal samples are ignored. clr -> err=0, state IDLE, counters 0.
- CNT_W=4: 17 consecutive lt samples -> lt_cnt saturates at 15, out_valid still pulses for each sample.
- clr and in_valid (eq) asserted in the same cycle -> sample dropped, eq_cnt=0, out_valid=0. rst mid-streak (3 eq samples, LOCK_N=4) followed by 1 eq -> eq_lock stays 0.

Source files
------------

// File: rtl/cmp_result_monitor_if.sv
// Comparator flag bus feeding the result monitor,
// plus the monitor's registered status outputs.
interface cmp_result_monitor_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             clr;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [1:0]       last_res;
  logic             out_valid;
  logic             eq_lock;
  logic             err;

  modport master (
    output in_valid, a_gt_b, a_lt_b, a_eq_b, clr,
    input  gt_cnt, lt_cnt, eq_cnt, last_res,
    input  out_valid, eq_lock, err
  );

  modport slave (
    input  in_valid, a_gt_b, a_lt_b, a_eq_b, clr,
    output gt_cnt, lt_cnt, eq_cnt, last_res,
    output out_valid, eq_lock, err
  );
endinterface

// File: rtl/cmp_result_monitor.sv
// Samples comparator flags, keeps saturating class counts,
// detects runs of equal results and flags bad encodings.
module cmp_result_monitor #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4
) (
  input logic clk,
  input logic rst,
  cmp_result_monitor_if.slave bus
);

  localparam int SW = $clog2(LOCK_N + 1);
  localparam logic [SW-1:0] LOCK_V = SW'(LOCK_N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [SW-1:0]    streak;
  logic [SW-1:0]    streak_nxt;
  logic [CNT_W-1:0] gt_q;
  logic [CNT_W-1:0] lt_q;
  logic [CNT_W-1:0] eq_q;
  logic [1:0]       last_q;
  logic             ov_q;

  logic one_hot;
  logic live;
  logic legal;
  logic illegal;
  logic accept;

  assign one_hot = $onehot({bus.a_gt_b,
                            bus.a_lt_b,
                            bus.a_eq_b});
  assign live    = (state != S_ERR);
  assign legal   = bus.in_valid & one_hot;
  assign illegal = bus.in_valid & ~one_hot;
  assign accept  = live & legal;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next state and streak from the current sample class.
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    if (live && illegal) begin
      state_nxt = S_ERR;
    end else if (accept) begin
      unique case (1'b1)
        bus.a_eq_b: begin
          if (streak != LOCK_V)
            streak_nxt = streak + 1'b1;
          if (streak_nxt == LOCK_V)
            state_nxt = S_LOCK;
          else
            state_nxt = S_TRACK;
        end
        bus.a_gt_b,
        bus.a_lt_b: begin
          streak_nxt = '0;
          state_nxt  = S_TRACK;
        end
      endcase
    end
  end

  // State, streak, counters and result registers.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state  <= S_IDLE;
      streak <= '0;
      gt_q   <= '0;
      lt_q   <= '0;
      eq_q   <= '0;
      last_q <= 2'b00;
      ov_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      ov_q   <= accept;
      if (accept) begin
        unique case (1'b1)
          bus.a_gt_b: begin
            gt_q   <= sat_inc(gt_q);
            last_q <= 2'b01;
          end
          bus.a_lt_b: begin
            lt_q   <= sat_inc(lt_q);
            last_q <= 2'b10;
          end
          bus.a_eq_b: begin
            eq_q   <= sat_inc(eq_q);
            last_q <= 2'b11;
          end
        endcase
      end
    end
  end

  assign bus.gt_cnt    = gt_q;
  assign bus.lt_cnt    = lt_q;
  assign bus.eq_cnt    = eq_q;
  assign bus.last_res  = last_q;
  assign bus.out_valid = ov_q;
  assign bus.eq_lock   = (state == S_LOCK);
  assign bus.err       = (state == S_ERR);

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Bench for cmp_result_monitor: directed plan plus
// randomized traffic checked against a behavioural model.
module tb_cmp_result_monitor;

  localparam int CNT_W  = 4;
  localparam int LOCK_N = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cmp_result_monitor_if #(.CNT_W(CNT_W)) bus ();

  cmp_result_monitor #(
    .CNT_W (CNT_W),
    .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model: index 0 gt, 1 lt, 2 eq
  int mcnt[3];
  int mlast;
  int mstreak;
  bit merr;
  bit mlock;
  bit mov;

  function automatic void chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               n, $time, act, exp);
    end
  endfunction

  task automatic model_step();
    int n;
    int k;
    if (rst || bus.clr) begin
      mcnt = '{0, 0, 0};
      mlast = 0;
      mstreak = 0;
      merr = 0;
      mlock = 0;
      mov = 0;
    end else if (merr || !bus.in_valid) begin
      mov = 0;
    end else begin
      n = int'(bus.a_gt_b) + int'(bus.a_lt_b)
        + int'(bus.a_eq_b);
      if (n != 1) begin
        merr = 1;
        mlock = 0;
        mov = 0;
      end else begin
        mov = 1;
        k = bus.a_gt_b ? 0 : (bus.a_lt_b ? 1 : 2);
        if (mcnt[k] < MAXC) mcnt[k]++;
        mlast = k + 1;
        if (k == 2) begin
          if (mstreak < LOCK_N) mstreak++;
          if (mstreak == LOCK_N) mlock = 1;
        end else begin
          mstreak = 0;
          mlock = 0;
        end
      end
    end
  endtask

  // Whole-output comparison against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gt_cnt", int'(bus.gt_cnt), mcnt[0]);
      chk("lt_cnt", int'(bus.lt_cnt), mcnt[1]);
      chk("eq_cnt", int'(bus.eq_cnt), mcnt[2]);
      chk("last_res", int'(bus.last_res), mlast);
      chk("out_valid", int'(bus.out_valid), int'(mov));
      chk("eq_lock", int'(bus.eq_lock), int'(mlock));
      chk("err", int'(bus.err), int'(merr));
    end
  end

  task automatic step(input bit v, input bit g,
                      input bit l, input bit e,
                      input bit c, input bit r);
    @(negedge clk);
    bus.in_valid = v;
    bus.a_gt_b = g;
    bus.a_lt_b = l;
    bus.a_eq_b = e;
    bus.clr = c;
    rst = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cmpab(input int a, input int b);
    step(1, a > b, a < b, a == b, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear();
    step(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int r;
    bit v;
    bit g;
    bit l;
    bit e;
    bus.in_valid = 0;
    bus.a_gt_b = 0;
    bus.a_lt_b = 0;
    bus.a_eq_b = 0;
    bus.clr = 0;
    mcnt = '{0, 0, 0};
    mlast = 0;
    mstreak = 0;
    merr = 0;
    mlock = 0;
    mov = 0;

    // reset held two cycles
    step(0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    idle();
    chk("rst_gt", int'(bus.gt_cnt), 0);
    chk("rst_last", int'(bus.last_res), 0);
    chk("rst_err", int'(bus.err), 0);

    // gt, lt, eq, gt
    cmpab(14, 10);
    chk("ov_first", int'(bus.out_valid), 1);
    cmpab(14, 15);
    cmpab(14, 14);
    cmpab(12, 10);
    idle();
    chk("mix_gt", int'(bus.gt_cnt), 2);
    chk("mix_lt", int'(bus.lt_cnt), 1);
    chk("mix_eq", int'(bus.eq_cnt), 1);
    chk("mix_last", int'(bus.last_res), 1);
    chk("mix_lock", int'(bus.eq_lock), 0);
    chk("mix_ov", int'(bus.out_valid), 0);

    // lock with a gap between 2nd and 3rd eq
    clear();
    cmpab(14, 14);
    cmpab(14, 14);
    idle();
    cmpab(14, 14);
    chk("lock_early", int'(bus.eq_lock), 0);
    cmpab(14, 14);
    chk("lock_rise", int'(bus.eq_lock), 1);
    cmpab(12, 10);
    chk("lock_fall", int'(bus.eq_lock), 0);
    chk("lock_eqcnt", int'(bus.eq_cnt), 4);

    // illegal encoding then ignored samples
    step(1, 1, 0, 1, 0, 0);
    chk("ill_err", int'(bus.err), 1);
    chk("ill_ov", int'(bus.out_valid), 0);
    chk("ill_gt", int'(bus.gt_cnt), 1);
    cmpab(3, 9);
    cmpab(9, 3);
    chk("ill_frz_lt", int'(bus.lt_cnt), 0);
    chk("ill_frz_ov", int'(bus.out_valid), 0);
    clear();
    chk("clr_err", int'(bus.err), 0);
    chk("clr_eq", int'(bus.eq_cnt), 0);

    // lt saturation
    for (int i = 0; i < 17; i++) cmpab(1, 2);
    chk("sat_lt", int'(bus.lt_cnt), 15);
    chk("sat_ov", int'(bus.out_valid), 1);

    // clr with a sample in the same cycle
    step(1, 0, 0, 1, 1, 0);
    chk("clrv_eq", int'(bus.eq_cnt), 0);
    chk("clrv_ov", int'(bus.out_valid), 0);

    // reset mid-streak
    cmpab(5, 5);
    cmpab(5, 5);
    cmpab(5, 5);
    step(0, 0, 0, 0, 0, 1);
    cmpab(5, 5);
    chk("rst_streak", int'(bus.eq_lock), 0);
    chk("rst_streak_eq", int'(bus.eq_cnt), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        {g, l, e} = 3'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 3))
          0: {g, l, e} = 3'b100;
          1: {g, l, e} = 3'b010;
          default: {g, l, e} = 3'b001;
        endcase
      end
      step(v, g, l, e, r >= 1 && r < 7, r < 1);
    end

    idle();
    idle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
